// File: rtl/rec_beat_loader_if.sv
// Beat-stream input and packed-record output bundle for rec_beat_loader.
// master = beat source / record consumer, slave = the loader.
interface rec_beat_loader_if #(
    parameter int W   = 4,
    parameter int RW  = 221,
    parameter int BIW = 6
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           rec_valid;
    logic           rec_ready;
    logic [RW-1:0]  rec;
    logic [BIW-1:0] beat_idx;
    logic           err_frame;

    modport master (
        output in_valid, in_data, in_last, rec_ready,
        input  in_ready, rec_valid, rec, beat_idx, err_frame
    );

    modport slave (
        input  in_valid, in_data, in_last, rec_ready,
        output in_ready, rec_valid, rec, beat_idx, err_frame
    );
endinterface

// File: rtl/rec_beat_loader.sv
// Assembles a packed {t, x, y, z} record MSB-first from W-bit beats, then offers it on valid/ready.
// One beat per cycle while loading; in_ready low while the record is held.
module rec_beat_loader #(
    parameter int W   = 4,
    parameter int NY  = 6,
    parameter int NZ0 = 6,
    parameter int NZ1 = 8
) (
    input logic             clk,
    input logic             rst_n,
    rec_beat_loader_if.slave bus
);
    localparam int RW  = 1 + W + NY*W + NZ0*NZ1*W;
    localparam int NB  = 2 + NY + NZ0*NZ1;
    localparam int BIW = $clog2(NB);
    localparam int LW  = $clog2(RW);
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(NB - 1);
    localparam logic [BIW-1:0] Y_LAST    = BIW'(1 + NY);

    typedef enum logic [2:0] {LD_T, LD_X, LD_Y, LD_Z, FULL} state_t;

    state_t         state, state_nxt;
    logic [BIW-1:0] bidx, bidx_nxt;
    logic [RW-1:0]  rec_q;
    logic           err_q, err_nxt;
    logic           acc;
    logic [LW-1:0]  wr_lo;

    assign bus.in_ready  = rst_n && (state != FULL);
    assign bus.rec_valid = (state == FULL);
    assign bus.rec       = rec_q;
    assign bus.beat_idx  = bidx;
    assign bus.err_frame = err_q;
    assign acc           = bus.in_valid && bus.in_ready;

    // Every beat after the t bit is a full W-bit slot, packed downward from RW-2.
    always_comb begin
        wr_lo = '0;
        if (state != LD_T)
            wr_lo = LW'(RW - 1 - W*int'(bidx));
    end

    always_comb begin
        state_nxt = state;
        bidx_nxt  = bidx;
        err_nxt   = 1'b0;
        if (state == FULL) begin
            if (bus.rec_ready) begin
                state_nxt = LD_T;
                bidx_nxt  = '0;
            end
        end else if (acc) begin
            if (bidx == LAST_BEAT) begin
                bidx_nxt  = '0;
                state_nxt = bus.in_last ? FULL : LD_T;
                err_nxt   = !bus.in_last;
            end else if (bus.in_last) begin
                bidx_nxt  = '0;
                state_nxt = LD_T;
                err_nxt   = 1'b1;
            end else begin
                bidx_nxt = bidx + 1'b1;
                case (state)
                    LD_T:    state_nxt = LD_X;
                    LD_X:    state_nxt = LD_Y;
                    LD_Y:    state_nxt = (bidx == Y_LAST) ? LD_Z : LD_Y;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LD_T;
            bidx  <= '0;
            rec_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            bidx  <= bidx_nxt;
            err_q <= err_nxt;
            if (acc) begin
                if (state == LD_T)
                    rec_q[RW-1] <= bus.in_data[0];
                else
                    rec_q[wr_lo +: W] <= bus.in_data;
            end
        end
    end
endmodule
